s2mm_packet_mux: RTL and testbench
==================================

Name: s2mm_packet_mux

Overview:
- Return path of the multi-accelerator datapath. Drains per-accelerator sink FIFOs and merges them into one AXI Stream feeding the slave s2mm port of the MCDMA.
- Round-robin arbitration happens at packet granularity. Each output packet carries the source channel index on tdest and ends with tlast after a programmed word count.
- Registered output with a 2-entry buffer, so AXIS timing is decoupled from FIFO read latency.

Parameters:
- AXIS_DATA_WIDTH, 32, output stream data width; must be ≥ FIFO_DATA_WIDTH (zero-extended).
- FIFO_DATA_WIDTH, 32, width of each source FIFO word.
- AXIS_DEST_WIDTH, 4, tdest width; 2^AXIS_DEST_WIDTH ≥ NUM_FIFOS.
- NUM_FIFOS, 2, number of source FIFOs/channels.
- PKT_LEN_WIDTH, 16, width of packet-length configuration.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- pkt_len  in  PKT_LEN_WIDTH  words per packet; sampled at grant.
- fifo_rden  out  NUM_FIFOS  read enable per source FIFO.
- fifo_empty  in  NUM_FIFOS  empty flag per source FIFO.
- fifo_data  in  NUM_FIFOS*FIFO_DATA_WIDTH  concatenated read data; channel i at bits [i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH].
- DST_AXIS_tdata  out  AXIS_DATA_WIDTH  stream data.
- DST_AXIS_tdest  out  AXIS_DEST_WIDTH  source channel index.
- DST_AXIS_tlast  out  1  last word of packet.
- DST_AXIS_tvalid  out  1  stream valid.
- DST_AXIS_tready  in  1  stream ready from MCDMA.

Behaviour:
- Source FIFOs are standard, not FWFT: data appears on fifo_data one cycle after rden is asserted.
- Reset: state=IDLE; fifo_rden=0; tvalid=0, tlast=0, tdata=0, tdest=0; buffer empty; issued count=0; round-robin pointer=NUM_FIFOS-1, so channel 0 wins first.
- Reset mid-packet: partial packet abandoned. Words from an in-flight read are discarded; tvalid=0 the cycle after reset is sampled.
- FSM states:
  - IDLE: pick the first channel with !fifo_empty, searching round-robin from pointer+1 with wrap. On a hit: latch grant; latch len = (pkt_len==0 ? 1 : pkt_len); issued=0; go to STREAM. On no hit, stay in IDLE. Arbitration costs 1 cycle.
  - STREAM: fifo_rden[g] = !fifo_empty[g] && issued<len && (buffer occupancy + in-flight read) < 2. Only the granted bit can ever be 1. Each rden increments issued. When the issue that makes issued==len occurs, go to DRAIN.
  - DRAIN: wait until the last word has been accepted (tvalid && tready && tlast). Then set pointer=g and go to IDLE.
- The buffer entry tag {data, dest=g, last=(issued==len-1)} is computed at issue time and travels with the read. The entry is written the cycle after rden.
- Output presents the buffer head. AXIS rule: while tvalid=1 and tready=0, tdata/tdest/tlast hold stable.
- Throughput: 1 word/cycle sustained while the granted FIFO is non-empty and tready=1.
- Per-packet overhead: 1 IDLE cycle plus the drain of any buffered words.
- Empty FIFO mid-packet: stall with no rden and no timeout; the packet never interleaves with another channel.
- tready low: at most 2 words are buffered (occupancy plus in-flight never exceeds 2), then reads stop.
- Same-cycle write and pop of the buffer is legal; occupancy stays unchanged.
- pkt_len changes mid-packet have no effect until the next grant.
- Only the granted channel is read; non-granted channels are never touched.

Optional Feature:
- S2MM_PKT_CNT_EN defined: adds output port pkt_count, width NUM_FIFOS*32. It holds per-channel 32-bit counters that increment on each tlast handshake for the matching tdest, wrap at 2^32, and clear on rst.
- Undefined: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package s2mm_pkg: FSM state typedef (IDLE, STREAM, DRAIN); buffer depth constant OUT_BUF_DEPTH=2; buffer entry struct {data, dest, last}.
- One sub-module, s2mm_out_buf: 2-entry registered FIFO with occupancy output, valid/ready pop and write strobe.
- Arbiter and FSM stay in the top module.

Test Plan:
- NUM_FIFOS=2, pkt_len=4, ch0 holds 8 words A0..A7, ch1 empty, tready=1 → two packets, tdest=0, tlast on A3 and A7, no gaps within a packet.
- Both channels hold 4 words, pkt_len=2 → packet order ch0, ch1, ch0, ch1; tdest alternates 0,1,0,1; tlast every 2nd word.
- ch0 has 4 words, pkt_len=4, tready held low 10 cycles → exactly 2 rden pulses, then hold; tdata stays stable while stalled; all 4 words emitted in order once tready=1.
- ch0 has 3 words, pkt_len=5; push 2 more after 20 cycles → tvalid stays low after word 3; ch1 data is not read meanwhile; tlast on word 5.
- pkt_len=0 with 1 word in ch1 → single-beat packet, tlast=1, tdest=1.
- rst asserted mid-packet after 2 of 4 words → next cycle tvalid=0 and fifo_rden=0; after release, arbitration restarts at channel 0.

Source files
------------

// File: rtl/s2mm_pkg.sv
// Shared types for the s2mm packet mux: FSM states and the output-buffer entry.
package s2mm_pkg;

    localparam int OUT_BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } s2mm_state_e;

    // Default-width entry; the top overrides the buffer type with its own widths.
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  dest;
        logic        last;
    } s2mm_entry_t;

endpackage

// File: rtl/s2mm_out_buf.sv
// Two-entry registered output FIFO. The head register drives the AXIS outputs directly,
// so the stream holds stable while tready is low.
module s2mm_out_buf
    import s2mm_pkg::*;
#(
    parameter type entry_t = s2mm_entry_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_i,
    input  entry_t     wr_data_i,
    output logic       rd_valid_o,
    input  logic       rd_ready_i,
    output entry_t     rd_data_o,
    output logic [1:0] occ_o
);

    entry_t     head_q, tail_q;
    logic [1:0] occ_q;
    logic       pop;

    assign pop        = (occ_q != 2'd0) && rd_ready_i;
    assign rd_valid_o = (occ_q != 2'd0);
    assign rd_data_o  = head_q;
    assign occ_o      = occ_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            case (occ_q)
                2'd0: begin
                    if (wr_i) begin
                        head_q <= wr_data_i;
                        occ_q  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (wr_i && pop) begin
                        head_q <= wr_data_i;
                    end else if (pop) begin
                        occ_q <= 2'd0;
                    end else if (wr_i) begin
                        tail_q <= wr_data_i;
                        occ_q  <= 2'd2;
                    end
                end
                default: begin
                    // Full: a write can only arrive together with a pop.
                    if (pop) begin
                        head_q <= tail_q;
                        if (wr_i) tail_q <= wr_data_i;
                        else      occ_q  <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/s2mm_packet_mux.sv
// Packet-granular round-robin merge of standard (non-FWFT) sink FIFOs onto one AXIS stream.
// Optional per-channel packet counters on pkt_count when S2MM_PKT_CNT_EN is defined.
module s2mm_packet_mux
    import s2mm_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int AXIS_DEST_WIDTH = 4,
    parameter int NUM_FIFOS       = 2,
    parameter int PKT_LEN_WIDTH   = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [PKT_LEN_WIDTH-1:0]             pkt_len,
    output logic [NUM_FIFOS-1:0]                 fifo_rden,
    input  logic [NUM_FIFOS-1:0]                 fifo_empty,
    input  logic [NUM_FIFOS*FIFO_DATA_WIDTH-1:0] fifo_data,
    output logic [AXIS_DATA_WIDTH-1:0]           DST_AXIS_tdata,
    output logic [AXIS_DEST_WIDTH-1:0]           DST_AXIS_tdest,
    output logic                                 DST_AXIS_tlast,
    output logic                                 DST_AXIS_tvalid,
    input  logic                                 DST_AXIS_tready
`ifdef S2MM_PKT_CNT_EN
    ,
    output logic [NUM_FIFOS*32-1:0]              pkt_count
`endif
);

    localparam int GW = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;
    localparam logic [PKT_LEN_WIDTH-1:0] LEN_ONE = {{(PKT_LEN_WIDTH-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [AXIS_DATA_WIDTH-1:0] data;
        logic [AXIS_DEST_WIDTH-1:0] dest;
        logic                       last;
    } entry_t;

    s2mm_state_e              state_q;
    logic [GW-1:0]            grant_q, rr_ptr_q, arb_sel, arb_idx;
    logic                     arb_hit;
    logic [PKT_LEN_WIDTH-1:0] len_q, issued_q;
    logic                     infl_q, infl_last_q;
    logic                     rd_issue, buf_pop;
    logic [1:0]               occ;
    entry_t                   wr_entry, head;

    always_comb begin
        arb_hit = 1'b0;
        arb_sel = rr_ptr_q;
        arb_idx = rr_ptr_q;
        for (int k = 1; k <= NUM_FIFOS; k++) begin
            arb_idx = GW'((int'(rr_ptr_q) + k) % NUM_FIFOS);
            if (!arb_hit && !fifo_empty[arb_idx]) begin
                arb_hit = 1'b1;
                arb_sel = arb_idx;
            end
        end
    end

    assign buf_pop = DST_AXIS_tvalid && DST_AXIS_tready;

    // The slot freed by this cycle's pop counts as free, which keeps a 1 word/cycle stream.
    assign rd_issue = (state_q == STREAM) && !fifo_empty[grant_q] && (issued_q < len_q)
                    && (({1'b0, occ} + {2'b00, infl_q} - {2'b00, buf_pop}) < 3'd2);

    always_comb begin
        fifo_rden          = '0;
        fifo_rden[grant_q] = rd_issue;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= GW'(NUM_FIFOS - 1);
            len_q       <= '0;
            issued_q    <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            infl_q <= rd_issue;
            if (rd_issue) infl_last_q <= (issued_q == len_q - LEN_ONE);
            case (state_q)
                IDLE: begin
                    if (arb_hit) begin
                        grant_q  <= arb_sel;
                        len_q    <= (pkt_len == '0) ? LEN_ONE : pkt_len;
                        issued_q <= '0;
                        state_q  <= STREAM;
                    end
                end
                STREAM: begin
                    if (rd_issue) begin
                        issued_q <= issued_q + LEN_ONE;
                        if (issued_q + LEN_ONE == len_q) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (buf_pop && DST_AXIS_tlast) begin
                        rr_ptr_q <= grant_q;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Grant is frozen until the packet drains, so it still selects the in-flight word.
    always_comb begin
        wr_entry.data = AXIS_DATA_WIDTH'(fifo_data[grant_q*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH]);
        wr_entry.dest = AXIS_DEST_WIDTH'(grant_q);
        wr_entry.last = infl_last_q;
    end

    s2mm_out_buf #(
        .entry_t (entry_t)
    ) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .wr_i       (infl_q),
        .wr_data_i  (wr_entry),
        .rd_valid_o (DST_AXIS_tvalid),
        .rd_ready_i (DST_AXIS_tready),
        .rd_data_o  (head),
        .occ_o      (occ)
    );

    assign DST_AXIS_tdata = head.data;
    assign DST_AXIS_tdest = head.dest;
    assign DST_AXIS_tlast = head.last;

`ifdef S2MM_PKT_CNT_EN
    logic [NUM_FIFOS-1:0][31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_FIFOS; i++) begin
                if (buf_pop && DST_AXIS_tlast && (head.dest == AXIS_DEST_WIDTH'(i)))
                    cnt_q[i] <= cnt_q[i] + 32'd1;
            end
        end
    end

    assign pkt_count = cnt_q;
`endif

endmodule

// File: tb/tb_s2mm_packet_mux.sv
// Bench for s2mm_packet_mux: standard-FIFO source models, directed table, corner sequences
// and a randomized run scored against per-channel word queues and packet framing rules.
module tb_s2mm_packet_mux;

    localparam int DW = 32, FW = 32, TW = 4, NF = 2, LW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [LW-1:0]     pkt_len = '0;
    logic [NF-1:0]     fifo_rden;
    logic [NF-1:0]     fifo_empty;
    logic [NF*FW-1:0]  fifo_data = '0;
    logic [DW-1:0]     tdata;
    logic [TW-1:0]     tdest;
    logic              tlast, tvalid;
    logic              tready = 1'b0;
`ifdef S2MM_PKT_CNT_EN
    logic [NF*32-1:0]  pkt_count;
`endif

    always #5 clk = ~clk;

    s2mm_packet_mux #(
        .AXIS_DATA_WIDTH (DW),
        .FIFO_DATA_WIDTH (FW),
        .AXIS_DEST_WIDTH (TW),
        .NUM_FIFOS       (NF),
        .PKT_LEN_WIDTH   (LW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pkt_len         (pkt_len),
        .fifo_rden       (fifo_rden),
        .fifo_empty      (fifo_empty),
        .fifo_data       (fifo_data),
        .DST_AXIS_tdata  (tdata),
        .DST_AXIS_tdest  (tdest),
        .DST_AXIS_tlast  (tlast),
        .DST_AXIS_tvalid (tvalid),
        .DST_AXIS_tready (tready)
`ifdef S2MM_PKT_CNT_EN
        ,
        .pkt_count       (pkt_count)
`endif
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [TW-1:0] t;
        logic          l;
        int            cy;
    } beat_t;

    typedef struct {
        logic [LW-1:0] len;
        int            n0;
        int            n1;
        int            npk;
        logic [7:0]    dseq;   // bit p = expected tdest of packet p
    } vec_t;

    logic [FW-1:0] q  [NF][$];   // source FIFO contents
    logic [FW-1:0] ex [NF][$];   // words still expected at the output, per channel
    beat_t         beats[$];
    beat_t         bt;
    logic [NF-1:0] rden_l = '0;
    logic [FW-1:0] fw_tmp;
    int            rd_cnt [NF];
    int            cyc = 0;
    int            n_cmp = 0, n_bad = 0;
    logic          pv_stall = 1'b0;
    logic [DW+TW:0] pv_word = '0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    function automatic void upd_empty();
        for (int c = 0; c < NF; c++) fifo_empty[c] = (q[c].size() == 0);
    endfunction

    // Standard FIFO: the word appears one cycle after rden.
    always @(posedge clk) begin
        cyc++;
        for (int c = 0; c < NF; c++) begin
            if (rden_l[c]) begin
                rd_cnt[c]++;
                chk("rden_nonempty", 64'(q[c].size() != 0), 64'd1);
                if (q[c].size() != 0) begin
                    fw_tmp = q[c].pop_front();
                    fifo_data[c*FW +: FW] <= fw_tmp;
                end
            end
        end
        #1 upd_empty();
    end

    always @(negedge clk) begin
        #2;
        rden_l = fifo_rden;
        if (rst) begin
            pv_stall = 1'b0;
        end else begin
            if (fifo_rden != '0) chk("rden_onehot", 64'($onehot(fifo_rden)), 64'd1);
            if (pv_stall) begin
                chk("hold_valid", 64'(tvalid), 64'd1);
                chk("hold_word", 64'({tdata, tdest, tlast}), 64'(pv_word));
            end
            if (tvalid && tready) begin
                bt.d = tdata; bt.t = tdest; bt.l = tlast; bt.cy = cyc;
                beats.push_back(bt);
            end
            pv_stall = tvalid && !tready;
            pv_word  = {tdata, tdest, tlast};
        end
    end

    task automatic push(input int c, input logic [FW-1:0] w);
        q[c].push_back(w);
        ex[c].push_back(w);
        upd_empty();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        tready = 1'b0;
        for (int c = 0; c < NF; c++) begin
            q[c].delete();
            ex[c].delete();
        end
        upd_empty();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        beats.delete();
    endtask

    task automatic wait_beats(input int n, input int budget, input string name);
        int i;
        i = 0;
        while (beats.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(name, 64'(beats.size() >= n), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        int   leff, tot, i0, i1, bi, base0, base1, pos, cur, d;
        logic [DW-1:0] exp_d;

        tbl[0] = '{16'd4, 8, 0, 2, 8'b0000_0000};
        tbl[1] = '{16'd2, 4, 4, 4, 8'b0000_1010};
        tbl[2] = '{16'd0, 0, 1, 1, 8'b0000_0001};
        tbl[3] = '{16'd1, 2, 1, 3, 8'b0000_0010};
        tbl[4] = '{16'd3, 3, 6, 3, 8'b0000_0110};

        for (int c = 0; c < NF; c++) rd_cnt[c] = 0;
        upd_empty();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tlast",  64'(tlast),  64'd0);
        chk("rst_tdata",  64'(tdata),  64'd0);
        chk("rst_tdest",  64'(tdest),  64'd0);
        chk("rst_rden",   64'(fifo_rden), 64'd0);

        // Directed table: preloaded FIFOs, tready high
        for (int t = 0; t < 5; t++) begin
            do_reset();
            pkt_len = tbl[t].len;
            leff = (tbl[t].len == '0) ? 1 : int'(tbl[t].len);
            for (int i = 0; i < tbl[t].n0; i++) push(0, 32'hA000_0000 + i);
            for (int i = 0; i < tbl[t].n1; i++) push(1, 32'hB000_0000 + i);
            tready = 1'b1;
            tot = tbl[t].npk * leff;
            wait_beats(tot, 200, "tbl_beats");
            repeat (5) @(negedge clk);
            chk("tbl_total", 64'(beats.size()), 64'(tot));
            i0 = 0; i1 = 0; bi = 0;
            for (int p = 0; p < tbl[t].npk; p++) begin
                for (int k = 0; k < leff; k++) begin
                    if (tbl[t].dseq[p]) begin exp_d = 32'hB000_0000 + i1; i1++; end
                    else                begin exp_d = 32'hA000_0000 + i0; i0++; end
                    if (bi < beats.size()) begin
                        chk("tbl_dest", 64'(beats[bi].t), 64'(tbl[t].dseq[p]));
                        chk("tbl_data", 64'(beats[bi].d), 64'(exp_d));
                        chk("tbl_last", 64'(beats[bi].l), 64'(k == leff - 1));
                        if (k > 0) chk("tbl_nogap", 64'(beats[bi].cy - beats[bi-1].cy), 64'd1);
                    end
                    bi++;
                end
            end
        end

        // tready low: two reads fill the buffer, then the stream holds
        do_reset();
        pkt_len = 16'd4;
        for (int i = 0; i < 4; i++) push(0, 32'hD000_0000 + i);
        base0 = rd_cnt[0];
        repeat (10) @(negedge clk);
        chk("stall_reads", 64'(rd_cnt[0] - base0), 64'd2);
        chk("stall_tvalid", 64'(tvalid), 64'd1);
        chk("stall_tdata", 64'(tdata), 64'h0000_0000_D000_0000);
        tready = 1'b1;
        wait_beats(4, 50, "stall_beats");
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            chk("stall_data", 64'(beats[i].d), 64'(32'hD000_0000 + i));
            chk("stall_last", 64'(beats[i].l), 64'(i == 3));
        end

        // Source runs empty mid-packet: stall without touching the other channel
        do_reset();
        pkt_len = 16'd5;
        for (int i = 0; i < 3; i++) push(0, 32'hA000_0000 + i);
        push(1, 32'hB000_0000);
        push(1, 32'hB000_0001);
        tready = 1'b1;
        base1 = rd_cnt[1];
        repeat (20) @(negedge clk);
        chk("empty_beats", 64'(beats.size()), 64'd3);
        chk("empty_tvalid", 64'(tvalid), 64'd0);
        chk("empty_ch1_untouched", 64'(rd_cnt[1] - base1), 64'd0);
        push(0, 32'hA000_0003);
        push(0, 32'hA000_0004);
        wait_beats(5, 50, "empty_resume");
        for (int i = 0; i < 5 && i < beats.size(); i++) begin
            chk("empty_data", 64'(beats[i].d), 64'(32'hA000_0000 + i));
            chk("empty_dest", 64'(beats[i].t), 64'd0);
            chk("empty_last", 64'(beats[i].l), 64'(i == 4));
        end

        // Reset mid-packet: partial packet dropped, arbitration restarts at channel 0
        do_reset();
        pkt_len = 16'd1;
        push(0, 32'hA000_0000);
        tready = 1'b1;
        wait_beats(1, 30, "rstmid_first");
        repeat (3) @(negedge clk);
        pkt_len = 16'd4;
        for (int i = 0; i < 4; i++) push(1, 32'hB000_0000 + i);
        wait_beats(3, 40, "rstmid_partial");
        chk("rstmid_partial_dest", 64'(beats[beats.size()-1].t), 64'd1);
        push(0, 32'hC000_0000);
        push(0, 32'hC000_0001);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_tvalid", 64'(tvalid), 64'd0);
        chk("rstmid_rden", 64'(fifo_rden), 64'd0);
        rst = 1'b0;
        beats.delete();
        wait_beats(1, 30, "rstmid_restart");
        if (beats.size() > 0) begin
            chk("rstmid_dest", 64'(beats[0].t), 64'd0);
            chk("rstmid_data", 64'(beats[0].d), 64'h0000_0000_C000_0000);
        end

        // Randomized traffic against per-channel order and packet framing rules
        for (int r = 0; r < 3; r++) begin
            do_reset();
            pkt_len = LW'($urandom_range(0, 4));
            leff = (pkt_len == '0) ? 1 : int'(pkt_len);
            for (int n = 0; n < 1500; n++) begin
                @(negedge clk);
                tready = ($urandom_range(0, 3) != 0);
                for (int c = 0; c < NF; c++) begin
                    if ($urandom_range(0, 9) == 0 && q[c].size() < 12)
                        for (int k = 0; k < leff; k++) push(c, FW'($urandom));
                end
            end
            @(negedge clk);
            tready = 1'b1;
            repeat (150) @(negedge clk);
            chk("rnd_traffic", 64'(beats.size() > 0), 64'd1);
            pos = 0; cur = 0;
            foreach (beats[i]) begin
                if (pos == 0) cur = int'(beats[i].t);
                else          chk("rnd_no_interleave", 64'(beats[i].t), 64'(cur));
                chk("rnd_dest_range", 64'(beats[i].t < NF), 64'd1);
                chk("rnd_last", 64'(beats[i].l), 64'(pos == leff - 1));
                if (beats[i].t < NF) begin
                    d = int'(beats[i].t);
                    chk("rnd_avail", 64'(ex[d].size() != 0), 64'd1);
                    if (ex[d].size() != 0) chk("rnd_data", 64'(beats[i].d), 64'(ex[d].pop_front()));
                end
                pos = (pos + 1) % leff;
            end
            chk("rnd_pkt_closed", 64'(pos), 64'd0);
            for (int c = 0; c < NF; c++) chk("rnd_all_emitted", 64'(ex[c].size()), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
